// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with a per-register pending scoreboard.
// Reads are registered; optional same-cycle write-to-read bypass and hardwired zero register.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  input  logic [NUM_RD-1:0]        rd_en_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_pending_o,
  input  logic                     sb_set_i,
  input  logic [ADDR_W-1:0]        sb_addr_i,
  output logic [ADDR_W:0]          pending_cnt_o
);

  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [DATA_W-1:0]   mem_d [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_clr;
  logic [NUM_REGS-1:0] pend_d;
  logic [DATA_W-1:0]   rd_data_d [NUM_RD];
  logic [NUM_RD-1:0]   rd_pend_d;
  logic [ADDR_W:0]     cnt_d;

  function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // Later write ports overwrite earlier ones, so the highest index wins on a collision.
  always_comb begin
    mem_d    = mem_q;
    pend_clr = pend_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en_i[w] && !is_zero(wr_addr_i[w*ADDR_W +: ADDR_W])) begin
        mem_d[wr_addr_i[w*ADDR_W +: ADDR_W]]    = wr_data_i[w*DATA_W +: DATA_W];
        pend_clr[wr_addr_i[w*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    pend_d = pend_clr;
    if (sb_set_i && !is_zero(sb_addr_i)) begin
      pend_d[sb_addr_i] = 1'b1;
    end
  end

  // Bypassed reads see the post-clear pending bit but never this cycle's set.
  always_comb begin
    rd_pend_d = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      rd_data_d[r] = '0;
      if (!is_zero(rd_addr_i[r*ADDR_W +: ADDR_W])) begin
        if (BYPASS != 0) begin
          rd_data_d[r] = mem_d[rd_addr_i[r*ADDR_W +: ADDR_W]];
          rd_pend_d[r] = pend_clr[rd_addr_i[r*ADDR_W +: ADDR_W]];
        end else begin
          rd_data_d[r] = mem_q[rd_addr_i[r*ADDR_W +: ADDR_W]];
          rd_pend_d[r] = pend_q[rd_addr_i[r*ADDR_W +: ADDR_W]];
        end
      end
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, pend_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
      pend_q        <= '0;
      rd_data_o     <= '0;
      rd_pending_o  <= '0;
      pending_cnt_o <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= mem_d[i];
      end
      pend_q        <= pend_d;
      pending_cnt_o <= cnt_d;
      for (int r = 0; r < NUM_RD; r++) begin
        if (rd_en_i[r]) begin
          rd_data_o[r*DATA_W +: DATA_W] <= rd_data_d[r];
          rd_pending_o[r]               <= rd_pend_d[r];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a bypassing and a non-bypassing instance share stimulus;
// directed vectors with hand-derived results, then random traffic against a reference model.
module tb_reg_file_mp;

  logic        clk;
  logic        rst;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_pend_a, rd_pend_b;
  logic [5:0]  cnt_a, cnt_b;

  int n_total = 0;
  int n_pass  = 0;

  reg_file_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data_a), .rd_pending_o(rd_pend_a),
    .sb_set_i(sb_set), .sb_addr_i(sb_addr), .pending_cnt_o(cnt_a));

  reg_file_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(0), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b), .rd_pending_o(rd_pend_b),
    .sb_set_i(sb_set), .sb_addr_i(sb_addr), .pending_cnt_o(cnt_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural register contents, pending set, and expected held outputs.
  bit [31:0] m_reg [32];
  bit [31:0] m_pend;
  bit [31:0] e_ad [2];
  bit [31:0] e_bd [2];
  bit        e_ap [2];
  bit        e_bp [2];
  int        e_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic model_step();
    int a;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_reg[i] = 0;
      m_pend = 0;
      for (int r = 0; r < 2; r++) begin
        e_ad[r] = 0; e_bd[r] = 0; e_ap[r] = 0; e_bp[r] = 0;
      end
      e_cnt = 0;
      return;
    end
    for (int r = 0; r < 2; r++) begin
      if (rd_en[r]) begin
        a = int'(rd_addr[r*5 +: 5]);
        if (a == 0) begin
          e_ad[r] = 0; e_ap[r] = 0; e_bd[r] = 0; e_bp[r] = 0;
        end else begin
          e_bd[r] = m_reg[a];
          e_bp[r] = m_pend[a];
          if (wr_en[1] && int'(wr_addr[9:5]) == a) begin
            e_ad[r] = wr_data[63:32]; e_ap[r] = 0;
          end else if (wr_en[0] && int'(wr_addr[4:0]) == a) begin
            e_ad[r] = wr_data[31:0]; e_ap[r] = 0;
          end else begin
            e_ad[r] = m_reg[a]; e_ap[r] = m_pend[a];
          end
        end
      end
    end
    for (int w = 0; w < 2; w++) begin
      a = int'(wr_addr[w*5 +: 5]);
      if (wr_en[w] && a != 0) begin
        m_reg[a]  = wr_data[w*32 +: 32];
        m_pend[a] = 1'b0;
      end
    end
    if (sb_set && sb_addr != 0) m_pend[sb_addr] = 1'b1;
    e_cnt = $countones(m_pend);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("model a.rd_data0", rd_data_a[31:0],  e_ad[0]);
    chk("model a.rd_data1", rd_data_a[63:32], e_ad[1]);
    chk("model a.rd_pend",  {30'b0, rd_pend_a}, {30'b0, e_ap[1], e_ap[0]});
    chk("model b.rd_data0", rd_data_b[31:0],  e_bd[0]);
    chk("model b.rd_data1", rd_data_b[63:32], e_bd[1]);
    chk("model b.rd_pend",  {30'b0, rd_pend_b}, {30'b0, e_bp[1], e_bp[0]});
    chk("model a.cnt", {26'b0, cnt_a}, 32'(e_cnt));
    chk("model b.cnt", {26'b0, cnt_b}, 32'(e_cnt));
  endtask

  typedef struct {
    bit [31:0] rst, we, wa0, wa1, wd0, wd1, re, ra0, ra1, sb, sa;
    bit [31:0] ad0, ad1, ap, bd0, bd1, bp, cnt;
  } vec_t;

  vec_t vt [18];

  initial begin
    rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
    rd_en = '0; rd_addr = '0; sb_set = 1'b0; sb_addr = '0;
    for (int i = 0; i < 32; i++) m_reg[i] = 0;
    m_pend = 0; e_cnt = 0;
    for (int r = 0; r < 2; r++) begin
      e_ad[r] = 0; e_bd[r] = 0; e_ap[r] = 0; e_bp[r] = 0;
    end

    //        rst we wa0 wa1 wd0            wd1      re ra0 ra1 sb sa | a.d0          a.d1      ap b.d0          b.d1     bp cnt
    vt[0]  = '{1, 0, 0,  0,  0,             0,       0, 0,  0,  0, 0,   0,            0,        0, 0,            0,       0, 0};
    vt[1]  = '{0, 1, 5,  0,  32'hDEADBEEF,  0,       0, 0,  0,  0, 0,   0,            0,        0, 0,            0,       0, 0};
    vt[2]  = '{0, 0, 0,  0,  0,             0,       1, 5,  0,  0, 0,   32'hDEADBEEF, 0,        0, 32'hDEADBEEF, 0,       0, 0};
    vt[3]  = '{0, 1, 7,  0,  32'h1234,      0,       3, 7,  7,  0, 0,   32'h1234,     32'h1234, 0, 0,            0,       0, 0};
    vt[4]  = '{0, 0, 0,  0,  0,             0,       3, 7,  7,  0, 0,   32'h1234,     32'h1234, 0, 32'h1234,     32'h1234, 0, 0};
    vt[5]  = '{0, 1, 0,  0,  32'hFFFFFFFF,  0,       3, 0,  7,  1, 0,   0,            32'h1234, 0, 0,            32'h1234, 0, 0};
    vt[6]  = '{0, 3, 3,  3,  32'hAAAA,      32'h5555, 1, 3, 0,  0, 0,   32'h5555,     32'h1234, 0, 0,            32'h1234, 0, 0};
    vt[7]  = '{0, 0, 0,  0,  0,             0,       1, 3,  0,  0, 0,   32'h5555,     32'h1234, 0, 32'h5555,     32'h1234, 0, 0};
    vt[8]  = '{0, 0, 0,  0,  0,             0,       0, 0,  0,  1, 9,   32'h5555,     32'h1234, 0, 32'h5555,     32'h1234, 0, 1};
    vt[9]  = '{0, 0, 0,  0,  0,             0,       1, 9,  0,  0, 0,   0,            32'h1234, 1, 0,            32'h1234, 1, 1};
    vt[10] = '{0, 1, 9,  0,  32'h99,        0,       2, 0,  9,  1, 9,   0,            32'h99,   1, 0,            0,       3, 1};
    vt[11] = '{0, 1, 9,  0,  32'h77,        0,       1, 9,  0,  0, 0,   32'h77,       32'h99,   0, 32'h99,       0,       3, 0};
    vt[12] = '{0, 3, 1,  2,  32'h11,        32'h22,  0, 0,  0,  1, 1,   32'h77,       32'h99,   0, 32'h99,       0,       3, 1};
    vt[13] = '{0, 0, 0,  0,  0,             0,       0, 0,  0,  1, 2,   32'h77,       32'h99,   0, 32'h99,       0,       3, 2};
    vt[14] = '{0, 1, 3,  0,  32'h33,        0,       0, 0,  0,  1, 3,   32'h77,       32'h99,   0, 32'h99,       0,       3, 3};
    vt[15] = '{0, 0, 0,  0,  0,             0,       0, 0,  0,  1, 4,   32'h77,       32'h99,   0, 32'h99,       0,       3, 4};
    vt[16] = '{1, 1, 2,  0,  32'hBAD,       0,       3, 1,  2,  1, 5,   0,            0,        0, 0,            0,       0, 0};
    vt[17] = '{0, 0, 0,  0,  0,             0,       3, 2,  1,  0, 0,   0,            0,        0, 0,            0,       0, 0};

    for (int i = 0; i < 18; i++) begin
      rst     = vt[i].rst[0];
      wr_en   = vt[i].we[1:0];
      wr_addr = {vt[i].wa1[4:0], vt[i].wa0[4:0]};
      wr_data = {vt[i].wd1, vt[i].wd0};
      rd_en   = vt[i].re[1:0];
      rd_addr = {vt[i].ra1[4:0], vt[i].ra0[4:0]};
      sb_set  = vt[i].sb[0];
      sb_addr = vt[i].sa[4:0];
      cycle();
      chk($sformatf("vec%0d a.rd_data0", i), rd_data_a[31:0],  vt[i].ad0);
      chk($sformatf("vec%0d a.rd_data1", i), rd_data_a[63:32], vt[i].ad1);
      chk($sformatf("vec%0d a.rd_pend", i),  {30'b0, rd_pend_a}, vt[i].ap);
      chk($sformatf("vec%0d b.rd_data0", i), rd_data_b[31:0],  vt[i].bd0);
      chk($sformatf("vec%0d b.rd_data1", i), rd_data_b[63:32], vt[i].bd1);
      chk($sformatf("vec%0d b.rd_pend", i),  {30'b0, rd_pend_b}, vt[i].bp);
      chk($sformatf("vec%0d a.cnt", i), {26'b0, cnt_a}, vt[i].cnt);
      chk($sformatf("vec%0d b.cnt", i), {26'b0, cnt_b}, vt[i].cnt);
    end

    // Fill every register pending, then clear them all through writes on both ports.
    rst = 1'b0; rd_en = '0; wr_en = '0;
    for (int i = 1; i < 32; i++) begin
      sb_set = 1'b1; sb_addr = 5'(i);
      cycle();
    end
    chk("full scoreboard cnt", {26'b0, cnt_a}, 32'd31);
    sb_set = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_en   = 2'b11;
      wr_addr = {5'(2*i + 1), 5'(2*i)};
      wr_data = {32'(i + 100), 32'(i + 200)};
      cycle();
    end
    chk("drained scoreboard cnt", {26'b0, cnt_b}, 32'd0);

    // Random traffic, biased toward a small address window to provoke collisions.
    for (int n = 0; n < 800; n++) begin
      rst    = ($urandom_range(0, 79) == 0);
      wr_en  = 2'($urandom_range(0, 3));
      rd_en  = 2'($urandom_range(0, 3));
      sb_set = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < 2; k++) begin
        wr_addr[k*5 +: 5] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        rd_addr[k*5 +: 5] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        wr_data[k*32 +: 32] = $urandom;
      end
      sb_addr = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
